// File: rtl/board_draw_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : board_draw_engine                                                 |
// | Purpose : Raster-sweeps board, opening pieces and cursor frame to the VGA.  |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module board_draw_engine #(
   parameter int         CELL     = 14,
   parameter int         ORIGIN_X = 24,
   parameter int         ORIGIN_Y = 4,
   parameter logic [2:0] C_BOARD  = 3'b010,
   parameter logic [2:0] C_GRID   = 3'b000,
   parameter logic [2:0] C_WHITE  = 3'b111,
   parameter logic [2:0] C_BLACK  = 3'b000,
   parameter logic [2:0] C_HL     = 3'b110
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       drawBoardEn,
   input  logic       drawInitialPiecesEn,
   input  logic       moveHighlightEn,
   input  logic       clearPiecesEn,
   input  logic [2:0] cursor_col,
   input  logic [2:0] cursor_row,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       go
);

   localparam int OW = $clog2(8*CELL+1);
   localparam int MW = $clog2(CELL);

   localparam logic [OW-1:0] c_boardHi = OW'(8*CELL);
   localparam logic [OW-1:0] c_cellHi  = OW'(CELL);
   localparam logic [OW-1:0] c_pieceHi = OW'(CELL-1);
   localparam logic [OW-1:0] c_pieceLo = OW'(1);
   localparam logic [OW-1:0] c_inLo    = OW'(3);
   localparam logic [OW-1:0] c_inHi    = OW'(CELL-3);
   localparam logic [MW-1:0] c_modHi   = MW'(CELL-1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BOARD    = 3'd1,
      S_PIECES   = 3'd2,
      S_HL_ERASE = 3'd3,
      S_HL_DRAW  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t        r_state, w_nextState, w_mode;
   logic [OW-1:0] r_ox, r_oy, w_ox, w_oy, w_nextOx, w_nextOy, w_hi, w_lo;
   logic [MW-1:0] r_mx, r_my, w_mx, w_my, w_nextMx, w_nextMy;
   logic [1:0]    r_cell, w_cell, w_nextCell;
   logic          r_tail, w_nextTail, w_step, w_wrapEnd, w_inner, w_edge;
   logic [2:0]    r_curCol, r_curRow, r_prevCol, r_prevRow;
   logic [2:0]    w_nextCurCol, w_nextCurRow, w_nextPrevCol, w_nextPrevRow;
   logic [2:0]    w_col, w_row;
   logic [7:0]    w_nextX;
   logic [6:0]    w_nextY;
   logic [2:0]    w_nextColour;
   logic          w_nextPlot, w_nextGo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ox      <= '0;
         r_oy      <= '0;
         r_mx      <= '0;
         r_my      <= '0;
         r_cell    <= '0;
         r_tail    <= 1'b0;
         r_curCol  <= '0;
         r_curRow  <= '0;
         r_prevCol <= '0;
         r_prevRow <= '0;
         x         <= '0;
         y         <= '0;
         colour    <= '0;
         plot      <= 1'b0;
         go        <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_ox      <= w_nextOx;
         r_oy      <= w_nextOy;
         r_mx      <= w_nextMx;
         r_my      <= w_nextMy;
         r_cell    <= w_nextCell;
         r_tail    <= w_nextTail;
         r_curCol  <= w_nextCurCol;
         r_curRow  <= w_nextCurRow;
         r_prevCol <= w_nextPrevCol;
         r_prevRow <= w_nextPrevRow;
         x         <= w_nextX;
         y         <= w_nextY;
         colour    <= w_nextColour;
         plot      <= w_nextPlot;
         go        <= w_nextGo;
      end
   end

   // Counters always point at the next pixel to emit; IDLE substitutes the start
   // position so the first pixel is registered on the accepting edge.
   always_comb begin
      w_nextState   = r_state;
      w_nextOx      = r_ox;
      w_nextOy      = r_oy;
      w_nextMx      = r_mx;
      w_nextMy      = r_my;
      w_nextCell    = r_cell;
      w_nextTail    = r_tail;
      w_nextCurCol  = r_curCol;
      w_nextCurRow  = r_curRow;
      w_nextPrevCol = r_prevCol;
      w_nextPrevRow = r_prevRow;
      w_nextX       = x;
      w_nextY       = y;
      w_nextColour  = colour;
      w_nextPlot    = 1'b0;
      w_nextGo      = 1'b0;
      w_mode        = S_IDLE;
      w_ox          = r_ox;
      w_oy          = r_oy;
      w_mx          = r_mx;
      w_my          = r_my;
      w_cell        = r_cell;
      w_step        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (clearPiecesEn || drawBoardEn) begin
               w_mode = S_BOARD;
               w_ox   = '0;
               w_oy   = '0;
               w_mx   = '0;
               w_my   = '0;
               w_step = 1'b1;
            end else if (drawInitialPiecesEn) begin
               w_mode = S_PIECES;
               w_ox   = c_pieceLo;
               w_oy   = c_pieceLo;
               w_cell = '0;
               w_step = 1'b1;
            end else if (moveHighlightEn) begin
               w_mode       = S_HL_ERASE;
               w_ox         = '0;
               w_oy         = '0;
               w_step       = 1'b1;
               w_nextCurCol = cursor_col;
               w_nextCurRow = cursor_row;
            end
         end
         S_BOARD, S_PIECES, S_HL_ERASE, S_HL_DRAW: begin
            if (r_tail) begin
               w_nextTail  = 1'b0;
               w_nextGo    = 1'b1;
               w_nextState = S_DONE;
               if (r_state == S_HL_DRAW) begin
                  w_nextPrevCol = r_curCol;
                  w_nextPrevRow = r_curRow;
               end
            end else begin
               w_mode = r_state;
               w_step = 1'b1;
            end
         end
         default: w_nextState = S_IDLE;
      endcase

      w_hi  = c_cellHi;
      w_lo  = '0;
      w_col = '0;
      w_row = '0;
      case (w_mode)
         S_BOARD: w_hi = c_boardHi;
         S_PIECES: begin
            w_hi  = c_pieceHi;
            w_lo  = c_pieceLo;
            w_col = 3'd3 + {2'b00, w_cell[0]};
            w_row = 3'd3 + {2'b00, w_cell[1]};
         end
         S_HL_ERASE: begin
            w_col = r_prevCol;
            w_row = r_prevRow;
         end
         S_HL_DRAW: begin
            w_col = r_curCol;
            w_row = r_curRow;
         end
         default: ;
      endcase

      w_wrapEnd = (w_ox == w_hi) && (w_oy == w_hi);
      w_inner   = (w_ox >= c_inLo) && (w_ox <= c_inHi) && (w_oy >= c_inLo) && (w_oy <= c_inHi);
      w_edge    = (w_ox == '0) || (w_ox == c_cellHi) || (w_oy == '0) || (w_oy == c_cellHi);

      if (w_step) begin
         w_nextX     = 8'(ORIGIN_X) + 8'(w_col) * 8'(CELL) + 8'(w_ox);
         w_nextY     = 7'(ORIGIN_Y) + 7'(w_row) * 7'(CELL) + 7'(w_oy);
         w_nextState = w_mode;
         case (w_mode)
            S_BOARD: begin
               w_nextColour = (w_mx == '0 || w_my == '0) ? C_GRID : C_BOARD;
               w_nextPlot   = 1'b1;
            end
            S_PIECES: begin
               w_nextColour = !w_inner ? C_BOARD :
                              (w_cell[0] == w_cell[1]) ? C_WHITE : C_BLACK;
               w_nextPlot   = 1'b1;
            end
            default: begin
               w_nextColour = (w_mode == S_HL_ERASE) ? C_GRID : C_HL;
               w_nextPlot   = w_edge;
            end
         endcase

         // mx/my shadow ox/oy modulo CELL so grid lines need no divider
         if (w_ox != w_hi) begin
            w_nextOx = w_ox + OW'(1);
            w_nextMx = (w_mx == c_modHi) ? '0 : w_mx + MW'(1);
            w_nextOy = w_oy;
            w_nextMy = w_my;
         end else begin
            w_nextOx = w_lo;
            w_nextMx = '0;
            w_nextOy = (w_oy != w_hi) ? w_oy + OW'(1) : w_lo;
            w_nextMy = (w_oy == w_hi || w_my == c_modHi) ? '0 : w_my + MW'(1);
         end
         w_nextCell = w_cell;

         if (w_wrapEnd) begin
            case (w_mode)
               S_PIECES: begin
                  if (w_cell == 2'd3) w_nextTail = 1'b1;
                  else                w_nextCell = w_cell + 2'd1;
               end
               S_HL_ERASE: w_nextState = S_HL_DRAW;
               default:    w_nextTail  = 1'b1;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_board_draw_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_board_draw_engine                                              |
// | Purpose : Scoreboard bench for board_draw_engine sweeps and go handshake.   |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module tb_board_draw_engine;

   localparam int CELL = 14;
   localparam int OX   = 24;
   localparam int OY   = 4;
   localparam int BOARD_PLOTS = (8*CELL+1)*(8*CELL+1);

   logic       clk = 1'b0;
   logic       reset;
   logic       drawBoardEn, drawInitialPiecesEn, moveHighlightEn, clearPiecesEn;
   logic [2:0] cursor_col, cursor_row;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, go;

   always #5 clk = ~clk;

   board_draw_engine dut (
      .clk                 (clk),
      .reset               (reset),
      .drawBoardEn         (drawBoardEn),
      .drawInitialPiecesEn (drawInitialPiecesEn),
      .moveHighlightEn     (moveHighlightEn),
      .clearPiecesEn       (clearPiecesEn),
      .cursor_col          (cursor_col),
      .cursor_row          (cursor_row),
      .x                   (x),
      .y                   (y),
      .colour              (colour),
      .plot                (plot),
      .go                  (go)
   );

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   pix_t expQ[$];
   pix_t gotQ[$];
   int   checks = 0;
   int   errors = 0;
   int   goCount, lastPlotCyc, goCyc, firstPlotCyc;
   bit   timedOut;

   function automatic pix_t mk(int ax, int ay, logic [2:0] c);
      pix_t p;
      p.px = 8'(ax);
      p.py = 7'(ay);
      p.pc = c;
      return p;
   endfunction

   function automatic void model_board();
      for (int oy = 0; oy <= 8*CELL; oy++)
         for (int ox = 0; ox <= 8*CELL; ox++)
            expQ.push_back(mk(OX+ox, OY+oy, (ox%CELL == 0 || oy%CELL == 0) ? 3'b000 : 3'b010));
   endfunction

   function automatic void model_pieces();
      for (int k = 0; k < 4; k++)
         for (int oy = 1; oy <= CELL-1; oy++)
            for (int ox = 1; ox <= CELL-1; ox++) begin
               logic [2:0] pcol;
               pcol = (k == 0 || k == 3) ? 3'b111 : 3'b000;
               if (!(ox >= 3 && ox <= CELL-3 && oy >= 3 && oy <= CELL-3)) pcol = 3'b010;
               expQ.push_back(mk(OX+(3+k%2)*CELL+ox, OY+(3+k/2)*CELL+oy, pcol));
            end
   endfunction

   function automatic void model_frame(int col, int row, logic [2:0] c);
      for (int oy = 0; oy <= CELL; oy++)
         for (int ox = 0; ox <= CELL; ox++)
            if (ox == 0 || ox == CELL || oy == 0 || oy == CELL)
               expQ.push_back(mk(OX+col*CELL+ox, OY+row*CELL+oy, c));
   endfunction

   function automatic int find_pix(int ax, int ay);
      foreach (gotQ[i])
         if (gotQ[i].px == 8'(ax) && gotQ[i].py == 7'(ay)) return int'(gotQ[i].pc);
      return -1;
   endfunction

   // Records plotted pixels and go timing; at the first go, applies the next
   // enable pattern {clear, board, pieces, highlight} as the control FSM would.
   task automatic collect(input int budget, input logic [3:0] nextEn, input int tail);
      int cyc;
      int after;
      bit seenGo;
      gotQ.delete();
      goCount = 0; lastPlotCyc = -1; goCyc = -1; firstPlotCyc = -1; timedOut = 0;
      cyc = 0; after = 0; seenGo = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (plot) begin
            gotQ.push_back(mk(int'(x), int'(y), colour));
            lastPlotCyc = cyc;
            if (firstPlotCyc < 0) firstPlotCyc = cyc;
         end
         if (go) begin
            goCount++;
            if (!seenGo) begin
               seenGo = 1;
               goCyc  = cyc;
               {clearPiecesEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn} = nextEn;
            end
         end
         if (seenGo) begin
            if (after >= tail) break;
            after++;
         end
         if (cyc >= budget) begin
            timedOut = 1;
            {clearPiecesEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn} = 4'b0000;
            break;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {clearPiecesEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn} = 4'b0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      reset = 1'b1;
      {clearPiecesEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn} = 4'b0000;
      cursor_col = 3'd0; cursor_row = 3'd0;
      repeat (2) @(negedge clk);
      checks++; if (plot !== 1'b0)  begin errors++; $display("FAIL reset_plot: got %b, expected 0", plot); end
      checks++; if (go !== 1'b0)    begin errors++; $display("FAIL reset_go: got %b, expected 0", go); end
      checks++; if (x !== 8'd0)     begin errors++; $display("FAIL reset_x: got %0d, expected 0", x); end
      checks++; if (y !== 7'd0)     begin errors++; $display("FAIL reset_y: got %0d, expected 0", y); end
      checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %b, expected 000", colour); end
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (plot || go) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles, expected 0", seen); end
   endtask

   task automatic test_board();
      pix_t g, e;
      expQ.delete();
      model_board();
      drawBoardEn = 1'b1;
      collect(BOARD_PLOTS + 100, 4'b0000, 4);
      checks++; if (timedOut) begin errors++; $display("FAIL board_timeout: got no go, expected go"); end
      checks++; if (gotQ.size() != BOARD_PLOTS) begin errors++; $display("FAIL board_count: got %0d, expected %0d", gotQ.size(), BOARD_PLOTS); end
      checks++; if (gotQ.size() == 0 || gotQ[0] !== mk(24, 4, 3'b000)) begin errors++; $display("FAIL board_first: got size %0d, expected (24,4) c=000 first", gotQ.size()); end
      checks++; if (find_pix(25, 5) != 2) begin errors++; $display("FAIL board_25_5: got %0d, expected 2", find_pix(25, 5)); end
      checks++; if (gotQ.size() == 0 || gotQ[gotQ.size()-1] !== mk(136, 116, 3'b000)) begin errors++; $display("FAIL board_last: expected (136,116) c=000 last"); end
      checks++; if (goCount != 1) begin errors++; $display("FAIL board_gocount: got %0d, expected 1", goCount); end
      checks++; if (goCyc != lastPlotCyc + 1) begin errors++; $display("FAIL board_gotiming: got go at %0d, last plot %0d", goCyc, lastPlotCyc); end
      while (gotQ.size() > 0 && expQ.size() > 0) begin
         g = gotQ.pop_front(); e = expQ.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL board_pixel: got (%0d,%0d) c=%b, expected (%0d,%0d) c=%b", g.px, g.py, g.pc, e.px, e.py, e.pc); end
      end
   endtask

   task automatic test_pieces();
      pix_t g, e;
      expQ.delete();
      model_pieces();
      drawInitialPiecesEn = 1'b1;
      collect(2000, 4'b0000, 4);
      checks++; if (timedOut) begin errors++; $display("FAIL pieces_timeout: got no go, expected go"); end
      checks++; if (gotQ.size() != 676) begin errors++; $display("FAIL pieces_count: got %0d, expected 676", gotQ.size()); end
      checks++; if (find_pix(73, 53) != 7) begin errors++; $display("FAIL pieces_73_53: got %0d, expected 7", find_pix(73, 53)); end
      checks++; if (find_pix(87, 53) != 0) begin errors++; $display("FAIL pieces_87_53: got %0d, expected 0", find_pix(87, 53)); end
      checks++; if (find_pix(67, 53) != 2) begin errors++; $display("FAIL pieces_67_53: got %0d, expected 2", find_pix(67, 53)); end
      checks++; if (goCount != 1) begin errors++; $display("FAIL pieces_gocount: got %0d, expected 1", goCount); end
      while (gotQ.size() > 0 && expQ.size() > 0) begin
         g = gotQ.pop_front(); e = expQ.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL pieces_pixel: got (%0d,%0d) c=%b, expected (%0d,%0d) c=%b", g.px, g.py, g.pc, e.px, e.py, e.pc); end
      end
   endtask

   task automatic test_highlight();
      pix_t g, e;
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         expQ.delete();
         if (pass == 0) begin
            model_frame(0, 0, 3'b000); model_frame(2, 5, 3'b110);
            cursor_col = 3'd2; cursor_row = 3'd5;
         end else begin
            model_frame(2, 5, 3'b000); model_frame(3, 5, 3'b110);
            cursor_col = 3'd3; cursor_row = 3'd5;
         end
         moveHighlightEn = 1'b1;
         collect(1000, 4'b0000, 4);
         checks++; if (gotQ.size() != 112) begin errors++; $display("FAIL hl_count%0d: got %0d, expected 112", pass, gotQ.size()); end
         checks++; if (goCount != 1) begin errors++; $display("FAIL hl_gocount%0d: got %0d, expected 1", pass, goCount); end
         if (pass == 0) begin
            checks++; if (find_pix(52, 74) != 6) begin errors++; $display("FAIL hl_corner: got %0d, expected 6", find_pix(52, 74)); end
         end
         while (gotQ.size() > 0 && expQ.size() > 0) begin
            g = gotQ.pop_front(); e = expQ.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL hl_pixel%0d: got (%0d,%0d) c=%b, expected (%0d,%0d) c=%b", pass, g.px, g.py, g.pc, e.px, e.py, e.pc); end
         end
      end
   endtask

   task automatic test_priority();
      pix_t g, e;
      expQ.delete();
      model_board();
      cursor_col = 3'd6; cursor_row = 3'd1;
      clearPiecesEn = 1'b1; moveHighlightEn = 1'b1;
      collect(BOARD_PLOTS + 100, 4'b0000, 4);
      checks++; if (gotQ.size() != BOARD_PLOTS) begin errors++; $display("FAIL prio_count: got %0d, expected %0d", gotQ.size(), BOARD_PLOTS); end
      checks++; if (goCount != 1) begin errors++; $display("FAIL prio_gocount: got %0d, expected 1", goCount); end
      while (gotQ.size() > 0 && expQ.size() > 0) begin
         g = gotQ.pop_front(); e = expQ.pop_front(); checks++;
         if (g !== e) begin errors++; $display("FAIL prio_pixel: got (%0d,%0d) c=%b, expected (%0d,%0d) c=%b", g.px, g.py, g.pc, e.px, e.py, e.pc); end
      end
   endtask

   task automatic test_reset_mid();
      int n, cyc, gos;
      n = 0; cyc = 0;
      drawBoardEn = 1'b1;
      while (n < 500 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (plot) n++;
      end
      checks++; if (n != 500) begin errors++; $display("FAIL midreset_reach: got %0d plots, expected 500", n); end
      reset = 1'b1;
      #1;
      checks++; if (plot !== 1'b0) begin errors++; $display("FAIL midreset_plot: got %b, expected 0", plot); end
      checks++; if (go !== 1'b0)   begin errors++; $display("FAIL midreset_go: got %b, expected 0", go); end
      drawBoardEn = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      gos = 0;
      repeat (5) begin
         @(negedge clk);
         if (go || plot) gos++;
      end
      checks++; if (gos != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles, expected 0", gos); end
      drawBoardEn = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!plot && cyc < 10);
      checks++; if (!plot || x !== 8'd24 || y !== 7'd4 || colour !== 3'b000) begin
         errors++; $display("FAIL midreset_restart: got plot=%b (%0d,%0d) c=%b, expected (24,4) c=000", plot, x, y, colour);
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      int totalGo;
      drawBoardEn = 1'b1;
      collect(BOARD_PLOTS + 100, 4'b0010, 0);
      totalGo = goCount;
      checks++; if (gotQ.size() != BOARD_PLOTS) begin errors++; $display("FAIL b2b_board_count: got %0d, expected %0d", gotQ.size(), BOARD_PLOTS); end
      collect(2000, 4'b0000, 4);
      totalGo += goCount;
      checks++; if (firstPlotCyc != 2) begin errors++; $display("FAIL b2b_latency: got first plot at %0d, expected 2", firstPlotCyc); end
      checks++; if (gotQ.size() == 0 || gotQ[0] !== mk(67, 47, 3'b010)) begin errors++; $display("FAIL b2b_first: got size %0d, expected (67,47) c=010 first", gotQ.size()); end
      checks++; if (gotQ.size() != 676) begin errors++; $display("FAIL b2b_pieces_count: got %0d, expected 676", gotQ.size()); end
      checks++; if (totalGo != 2) begin errors++; $display("FAIL b2b_gocount: got %0d, expected 2", totalGo); end
   endtask

   initial begin
      test_reset();
      test_board();
      test_pieces();
      test_highlight();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
